dm_responder: RTL
=================

Name: dm_responder

Overview:
Data-memory responder on the far side of the register file's data-memory port. It accepts word read and write requests over a req/ack handshake and services them from an internal word-addressed RAM. Read latency is programmable. Read data returns on rd, which feeds the register file's dmRd input.

Parameters:
DEPTH, 256, number of 32-bit words in the RAM; must be a power of two.
AW, 8, RAM index width; equals log2(DEPTH).
RD_LAT, 2, wait cycles a read spends in RD_WAIT; minimum 1.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
req  input  1  request strobe; sampled only in IDLE.
we  input  1  1 = write, 0 = read; qualified by req.
addr  input  32  word address (register-file dmWaddress).
wd  input  32  write data (register-file dmWd).
busy  output  1  high whenever the state is not IDLE.
ack  output  1  one-cycle completion pulse.
err  output  1  valid with ack; address was out of range.
rd  output  32  read data; valid with ack on reads.

Behaviour:
- Reset (rst=0 at an edge) forces state=IDLE, ack=0, err=0, busy=0, rd=0, wait counter=0. RAM contents are not cleared.
- Reset takes priority over everything else, including mid-operation. A pending write in WR is dropped (no RAM update on that edge). A pending read is dropped and produces no ack.
- FSM states: IDLE, RD_WAIT, WR, DONE.
- IDLE:
  - On an edge with req=1, capture we, addr and wd into holding registers.
  - If addr >= DEPTH (any bit above AW-1 set): go to DONE with err_next=1.
  - Else if we=1: go to WR.
  - Else: go to RD_WAIT with counter=RD_LAT-1.
- RD_WAIT:
  - While counter != 0, decrement each edge.
  - When counter == 0, load rd <= mem[addr_q] and go to DONE.
- WR: mem[addr_q] <= wd_q on this edge, then go to DONE.
- DONE:
  - ack=1 for exactly this one cycle.
  - err shows the captured error flag; err=0 in every other state.
  - Next edge returns to IDLE. req is ignored in DONE.
- Out-of-range requests: no RAM access, rd unchanged, err=1 with ack.
- Latency, counting edges from the req-sampling edge to the cycle where ack is high:
  - read: RD_LAT+1 edges, ack high in the cycle after that edge.
  - write: 2 edges.
  - error: 1 edge.
- Minimum request spacing: req is re-sampled only once IDLE is re-entered. A req held high continuously therefore issues a new request every (latency+1) cycles.
- req, we, addr and wd are don't-care while busy=1; captured values are stable for the whole operation.
- rd holds the last completed read value until the next successful read completes. Writes and errors do not change rd.
- A read of an address that was just written returns the new data. The write commits in WR, before any later read can be sampled.
- ack and busy are registered state decodes with no combinational path from req.

Test Plan:
1. Reset, then write addr=5 wd=0xDEADBEEF -> busy=1 for 2 cycles, ack pulse 2 edges after req, err=0, rd stays 0.
2. Read addr=5 with RD_LAT=2 -> ack exactly 3 edges after the req edge, rd=0xDEADBEEF, err=0; rd unchanged afterwards.
3. Read addr=0x100 (DEPTH=256) -> ack plus err=1 after 1 edge, rd holds its prior value, RAM unchanged (re-read of addr 0 returns its prior value).
4. req held high with alternating we; second request toggles while busy -> only the captured first request executes, and the next is accepted after DONE.
5. Write addr=7 wd=0x1234, rst=0 asserted in the WR cycle -> no ack; a later read of addr=7 returns the previous contents; all outputs 0 after reset.
6. Write all 256 addresses with wd=addr*3, then read them back -> every rd matches; addr=255 wraps correctly, with no aliasing into addr=0.

Source files
------------

// File: rtl/dm_responder.sv
// Data-memory responder: services word read/write requests from an internal RAM
// over a req/ack handshake, with a programmable read latency.
module dm_responder #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned AW     = 8,
    parameter int unsigned RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic        busy,
    output logic        ack,
    output logic        err,
    output logic [31:0] rd
);

    localparam int unsigned CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR, DONE} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wd_q;
    logic [31:0]     mem [DEPTH];
    logic            out_of_range;
    logic            capture;
    logic            err_next;
    logic            load_rd;
    logic            mem_wr;

    assign out_of_range = |addr[31:AW];

    // Next-state and datapath strobes.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        err_next   = 1'b0;
        capture    = 1'b0;
        load_rd    = 1'b0;
        mem_wr     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    if (out_of_range) begin
                        state_next = DONE;
                        err_next   = 1'b1;
                    end else if (we) begin
                        state_next = WR;
                    end else begin
                        state_next = RD_WAIT;
                        cnt_next   = CW'(RD_LAT - 1);
                    end
                end
            end
            RD_WAIT: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CW'(1);
                end else begin
                    load_rd    = 1'b1;
                    state_next = DONE;
                end
            end
            WR: begin
                mem_wr     = 1'b1;
                state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, counter and registered outputs; outputs are decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            ack   <= 1'b0;
            err   <= 1'b0;
            rd    <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            busy  <= (state_next != IDLE);
            ack   <= (state_next == DONE);
            err   <= err_next;
            if (load_rd) begin
                rd <= mem[idx_q];
            end
        end
    end

    // Holding registers and RAM; a write pending when reset hits is dropped.
    always_ff @(posedge clk) begin
        if (capture) begin
            idx_q <= addr[AW-1:0];
            wd_q  <= wd;
        end
        if (rst && mem_wr) begin
            mem[idx_q] <= wd_q;
        end
    end

endmodule
